// File: rtl/accumulator_bank_arbiter.sv
// Per-bank round-robin arbitration of product requests into accumulator banks.
// Same-bank, same-entry requests in one cycle merge into one summed write.
module accumulator_bank_arbiter #(
  parameter int REQ_COUNT  = 8,
  parameter int BANK_COUNT = 32,
  parameter int TILE_SIZE  = 128,
  parameter int DATA_WIDTH = 24,
  localparam int RW = $clog2(REQ_COUNT),
  localparam int BW = $clog2(BANK_COUNT),
  localparam int EW = $clog2(TILE_SIZE),
  localparam int CW = RW + 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  flush,
  input  logic [REQ_COUNT-1:0]                  req_valid,
  input  logic [REQ_COUNT-1:0][BW-1:0]          req_bank,
  input  logic [REQ_COUNT-1:0][EW-1:0]          req_entry,
  input  logic [REQ_COUNT-1:0][DATA_WIDTH-1:0]  req_value,
  output logic [REQ_COUNT-1:0]                  req_ready,
  output logic [BANK_COUNT-1:0]                 bank_write_enable,
  output logic [BANK_COUNT-1:0][EW-1:0]         bank_entry,
  output logic [BANK_COUNT-1:0][DATA_WIDTH-1:0] bank_value,
  output logic                                  idle,
  output logic [15:0]                           conflict_count
);

  logic [BANK_COUNT-1:0][RW-1:0]         r_rr_ptr;
  logic [BANK_COUNT-1:0]                 r_we;
  logic [BANK_COUNT-1:0][EW-1:0]         r_entry;
  logic [BANK_COUNT-1:0][DATA_WIDTH-1:0] r_value;
  logic [15:0]                           r_conf;

  logic [REQ_COUNT-1:0]                  w_ready;
  logic [BANK_COUNT-1:0]                 w_hit;
  logic [BANK_COUNT-1:0][RW-1:0]         w_win;
  logic [BANK_COUNT-1:0][EW-1:0]         w_entry;
  logic [BANK_COUNT-1:0][DATA_WIDTH-1:0] w_sum;
  logic [CW-1:0]                         w_stall;
  logic [16:0]                           w_conf_sum;
  logic [15:0]                           w_conf_next;

  always_comb begin
    logic          found;
    logic [RW-1:0] win;
    logic [RW-1:0] idx;
    w_ready = '0;
    w_hit   = '0;
    w_win   = '0;
    w_entry = '0;
    w_sum   = '0;
    w_stall = '0;
    for (int b = 0; b < BANK_COUNT; b++) begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      // First candidate at or above the pointer, wrapping around
      for (int k = 0; k < REQ_COUNT; k++) begin
        idx = r_rr_ptr[b] + RW'(k);
        if (!found && req_valid[idx] &&
            req_bank[idx] == BW'(b)) begin
          found = 1'b1;
          win   = idx;
        end
      end
      w_win[b]   = win;
      w_entry[b] = req_entry[win];
      for (int i = 0; i < REQ_COUNT; i++) begin
        if (found && !flush && !reset &&
            req_valid[i] &&
            req_bank[i] == BW'(b) &&
            req_entry[i] == req_entry[win]) begin
          w_ready[i] = 1'b1;
          w_hit[b]   = 1'b1;
          w_sum[b]   = w_sum[b] + req_value[i];
        end
      end
    end
    for (int i = 0; i < REQ_COUNT; i++) begin
      if (!flush)
        w_stall = w_stall + CW'(req_valid[i] & ~w_ready[i]);
    end
  end

  assign w_conf_sum  = {1'b0, r_conf} + 17'(w_stall);
  assign w_conf_next = w_conf_sum[16] ? 16'hFFFF : w_conf_sum[15:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= '0;
      r_we     <= '0;
      r_entry  <= '0;
      r_value  <= '0;
      r_conf   <= '0;
    end else if (flush) begin
      r_rr_ptr <= '0;
      r_we     <= '0;
      r_conf   <= '0;
    end else begin
      r_we   <= w_hit;
      r_conf <= w_conf_next;
      for (int b = 0; b < BANK_COUNT; b++) begin
        if (w_hit[b]) begin
          r_rr_ptr[b] <= w_win[b] + RW'(1);
          r_entry[b]  <= w_entry[b];
          r_value[b]  <= w_sum[b];
        end
      end
    end
  end

  assign req_ready         = w_ready;
  assign bank_write_enable = r_we;
  assign bank_entry        = r_entry;
  assign bank_value        = r_value;
  assign conflict_count    = r_conf;
  assign idle              = ~|req_valid & ~|r_we;

endmodule
